// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared types and constants for the MEM pipeline stage:
//               FSM state encoding, access-size masks, RAM port widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

    // Data-RAM port widths
    localparam int c_RAM_DATA_W = 32;
    localparam int c_RAM_STRB_W = 4;
    localparam int c_REG_ADDR_W = 5;

    // Access-size masks carried on mem_sel
    localparam logic [3:0] c_SEL_BYTE = 4'b0001;
    localparam logic [3:0] c_SEL_HALF = 4'b0011;
    localparam logic [3:0] c_SEL_WORD = 4'b1111;

    // MEM stage FSM encoding
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_e;

endpackage : mem_access_pkg

`default_nettype wire

// File: rtl/mem_lane_ext.sv
// ============================================================================
// Module      : mem_lane_ext
// Description : Combinational load-lane steering. Right-aligns the addressed
//               bytes of a RAM word and sign/zero extends byte or half
//               accesses; word accesses pass through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_ext
    import mem_access_pkg::*;
(
    input  logic [c_RAM_DATA_W-1:0] i_rdata,
    input  logic [1:0]              i_addr_lo,
    input  logic [3:0]              i_sel,
    input  logic                    i_ext,
    output logic [c_RAM_DATA_W-1:0] o_result
);

    logic [c_RAM_DATA_W-1:0] w_shifted;

    // Shift the addressed lane down to bit 0, then extend by access size
    always_comb begin
        w_shifted = i_rdata >> {i_addr_lo, 3'b000};
        o_result  = w_shifted;
        case (i_sel)
            c_SEL_BYTE: o_result = {{24{i_ext & w_shifted[7]}}, w_shifted[7:0]};
            c_SEL_HALF: o_result = {{16{i_ext & w_shifted[15]}}, w_shifted[15:0]};
            default:    o_result = w_shifted;
        endcase
    end

endmodule : mem_lane_ext

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// Module      : mem_access
// Description : Pipeline MEM stage. Passes ALU results to WB, and runs a
//               request/ready transaction on the data RAM for loads and
//               stores with byte-lane steering and load extension. Stalls the
//               pipeline while a transaction is outstanding.
//               Optional build macro: MEM_ALIGN_CHECK_EN (misalignment trap,
//               adds the mem_align_err port).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_flag,
    input  logic              mem_write_flag,
    input  logic              mem_ext_flag,
    input  logic [3:0]        mem_sel,
    input  logic [31:0]       mem_write_data,
    input  logic [31:0]       ex_result,
    input  logic              reg_write_en_in,
    input  logic [4:0]        reg_write_addr_in,
    input  logic [31:0]       current_pc_addr_in,
    output logic              stall_req,
    output logic              mem_load_flag,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_ready,
    output logic [31:0]       wb_result,
    output logic              wb_reg_write_en,
    output logic [4:0]        wb_reg_write_addr,
    output logic [31:0]       wb_pc
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              mem_align_err
`endif
);

    state_e                  r_state_q, r_state_d;
    logic                    r_ram_en_q, r_ram_en_d;
    logic [c_RAM_STRB_W-1:0] r_ram_we_q, r_ram_we_d;
    logic [ADDR_W-1:0]       r_ram_addr_q, r_ram_addr_d;
    logic [c_RAM_DATA_W-1:0] r_ram_wdata_q, r_ram_wdata_d;
    logic [1:0]              r_addr_lo_q, r_addr_lo_d;
    logic [3:0]              r_sel_q, r_sel_d;
    logic                    r_ext_q, r_ext_d;
    logic                    r_rd_q, r_rd_d;
    logic                    r_rwe_q, r_rwe_d;
    logic [c_REG_ADDR_W-1:0] r_rwaddr_q, r_rwaddr_d;
    logic [31:0]             r_pc_q, r_pc_d;
    logic [31:0]             r_wb_result_q, r_wb_result_d;
    logic                    r_wb_wen_q, r_wb_wen_d;
    logic [c_REG_ADDR_W-1:0] r_wb_waddr_q, r_wb_waddr_d;
    logic [31:0]             r_wb_pc_q, r_wb_pc_d;
`ifdef MEM_ALIGN_CHECK_EN
    logic                    r_align_err_q, r_align_err_d;
`endif

    logic                    w_mem_op;
    logic                    w_misaligned;
    logic [c_RAM_STRB_W-1:0] w_strobe;
    logic [c_RAM_DATA_W-1:0] w_wdata_steered;
    logic [c_RAM_DATA_W-1:0] w_load_val;

    assign w_mem_op        = mem_read_flag | mem_write_flag;
    // Strobes shifted past lane 3 fall off the 4-bit result
    assign w_strobe        = mem_sel << ex_result[1:0];
    assign w_wdata_steered = mem_write_data << {ex_result[1:0], 3'b000};

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = ((mem_sel == c_SEL_HALF) && ex_result[0]) ||
                          ((mem_sel == c_SEL_WORD) && (ex_result[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    // Load data path works from the held request, not the live EX inputs
    mem_lane_ext u_lane_ext (
        .i_rdata   (ram_rdata),
        .i_addr_lo (r_addr_lo_q),
        .i_sel     (r_sel_q),
        .i_ext     (r_ext_q),
        .o_result  (w_load_val)
    );

    // Next-state, request capture, writeback selection and stall outputs
    always_comb begin
        r_state_d     = r_state_q;
        r_ram_en_d    = r_ram_en_q;
        r_ram_we_d    = r_ram_we_q;
        r_ram_addr_d  = r_ram_addr_q;
        r_ram_wdata_d = r_ram_wdata_q;
        r_addr_lo_d   = r_addr_lo_q;
        r_sel_d       = r_sel_q;
        r_ext_d       = r_ext_q;
        r_rd_d        = r_rd_q;
        r_rwe_d       = r_rwe_q;
        r_rwaddr_d    = r_rwaddr_q;
        r_pc_d        = r_pc_q;
        r_wb_result_d = r_wb_result_q;
        r_wb_wen_d    = r_wb_wen_q;
        r_wb_waddr_d  = r_wb_waddr_q;
        r_wb_pc_d     = r_wb_pc_q;
`ifdef MEM_ALIGN_CHECK_EN
        r_align_err_d = 1'b0;
`endif
        stall_req     = 1'b0;
        mem_load_flag = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (w_mem_op) begin
                    r_wb_wen_d = 1'b0;
                    if (w_misaligned) begin
`ifdef MEM_ALIGN_CHECK_EN
                        r_align_err_d = 1'b1;
`endif
                    end else begin
                        stall_req     = 1'b1;
                        r_state_d     = ST_BUS;
                        r_ram_en_d    = 1'b1;
                        r_ram_addr_d  = {ex_result[ADDR_W-1:2], 2'b00};
                        r_ram_we_d    = mem_write_flag ? w_strobe : '0;
                        r_ram_wdata_d = w_wdata_steered;
                        r_addr_lo_d   = ex_result[1:0];
                        r_sel_d       = mem_sel;
                        r_ext_d       = mem_ext_flag;
                        r_rd_d        = mem_read_flag;
                        r_rwe_d       = reg_write_en_in;
                        r_rwaddr_d    = reg_write_addr_in;
                        r_pc_d        = current_pc_addr_in;
                    end
                end else begin
                    r_wb_result_d = ex_result;
                    r_wb_wen_d    = reg_write_en_in;
                    r_wb_waddr_d  = reg_write_addr_in;
                    r_wb_pc_d     = current_pc_addr_in;
                end
            end
            ST_BUS: begin
                mem_load_flag = r_rd_q;
                stall_req     = !ram_ready;
                if (ram_ready) begin
                    r_state_d    = ST_IDLE;
                    r_ram_en_d   = 1'b0;
                    r_ram_we_d   = '0;
                    r_wb_waddr_d = r_rwaddr_q;
                    r_wb_pc_d    = r_pc_q;
                    if (r_rd_q) begin
                        r_wb_result_d = w_load_val;
                        r_wb_wen_d    = r_rwe_q;
                    end else begin
                        r_wb_wen_d    = 1'b0;
                    end
                end
            end
            default: r_state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_ram_en_q    <= 1'b0;
            r_ram_we_q    <= '0;
            r_ram_addr_q  <= '0;
            r_ram_wdata_q <= '0;
            r_addr_lo_q   <= '0;
            r_sel_q       <= '0;
            r_ext_q       <= 1'b0;
            r_rd_q        <= 1'b0;
            r_rwe_q       <= 1'b0;
            r_rwaddr_q    <= '0;
            r_pc_q        <= '0;
            r_wb_result_q <= '0;
            r_wb_wen_q    <= 1'b0;
            r_wb_waddr_q  <= '0;
            r_wb_pc_q     <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            r_align_err_q <= 1'b0;
`endif
        end else begin
            r_state_q     <= r_state_d;
            r_ram_en_q    <= r_ram_en_d;
            r_ram_we_q    <= r_ram_we_d;
            r_ram_addr_q  <= r_ram_addr_d;
            r_ram_wdata_q <= r_ram_wdata_d;
            r_addr_lo_q   <= r_addr_lo_d;
            r_sel_q       <= r_sel_d;
            r_ext_q       <= r_ext_d;
            r_rd_q        <= r_rd_d;
            r_rwe_q       <= r_rwe_d;
            r_rwaddr_q    <= r_rwaddr_d;
            r_pc_q        <= r_pc_d;
            r_wb_result_q <= r_wb_result_d;
            r_wb_wen_q    <= r_wb_wen_d;
            r_wb_waddr_q  <= r_wb_waddr_d;
            r_wb_pc_q     <= r_wb_pc_d;
`ifdef MEM_ALIGN_CHECK_EN
            r_align_err_q <= r_align_err_d;
`endif
        end
    end

    assign ram_en            = r_ram_en_q;
    assign ram_we            = r_ram_we_q;
    assign ram_addr          = r_ram_addr_q;
    assign ram_wdata         = r_ram_wdata_q;
    assign wb_result         = r_wb_result_q;
    assign wb_reg_write_en   = r_wb_wen_q;
    assign wb_reg_write_addr = r_wb_waddr_q;
    assign wb_pc             = r_wb_pc_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign mem_align_err     = r_align_err_q;
`endif

endmodule : mem_access

`default_nettype wire
